// File: rtl/camera_cfg_pkg.sv
// Shared definitions for the camera register configuration sequencer:
// FSM state type and the fixed/default register words.
package camera_cfg_pkg;

  typedef enum logic [2:0] {
    WAIT_PWR,
    REQ,
    GAP,
    SETTLE,
    DONE,
    ERR
  } cfg_state_t;

  localparam logic [15:0] SOFT_RST_WORD = 16'h12_80;

  // Window words: mode one (default) and mode two
  localparam logic [15:0] X_DEF = 16'h5a_40;
  localparam logic [15:0] Y_DEF = 16'h5b_34;
  localparam logic [15:0] X_BIG = 16'h5a_C8;
  localparam logic [15:0] Y_BIG = 16'h5b_96;

endpackage

// File: rtl/camera_reg_rom.sv
// Fixed sensor register table, {reg_addr, reg_data} per entry; covers
// entries 0..REG_NUM-3, the window words are muxed in by the sequencer.
module camera_reg_rom
  import camera_cfg_pkg::*;
#(
  parameter int unsigned REG_NUM = 12
) (
  input  logic [$clog2(REG_NUM)-1:0] idx,
  output logic [15:0]                word
);

  localparam int unsigned IW        = $clog2(REG_NUM);
  localparam int unsigned ROM_DEPTH = 10;

  // Entry i lives at bits [i*16 +: 16]
  localparam logic [ROM_DEPTH*16-1:0] ROM_FLAT = {
    16'h0c_00, 16'h1a_7b, 16'h19_02, 16'h18_04, 16'h17_16,
    16'h32_80, 16'h40_d0, 16'h3a_04, 16'h11_01, SOFT_RST_WORD
  };

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < ROM_DEPTH; i++) begin
      if ((i + 2 < REG_NUM) && (idx == IW'(i))) begin
        word = ROM_FLAT[i*16 +: 16];
      end
    end
  end

endmodule

// File: rtl/camera_reg_seq.sv
// Camera register configuration sequencer: walks the register table after
// power-up or restart and issues one SCCB write request per entry.
module camera_reg_seq
  import camera_cfg_pkg::*;
#(
  parameter int unsigned REG_NUM     = 12,
  parameter int unsigned POWERUP_CYC = 20000,
  parameter int unsigned SETTLE_CYC  = 20000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        camera_rstn,
  input  logic [15:0] x_lenth,
  input  logic [15:0] y_lenth,
  output logic        sccb_req,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_data,
  input  logic        sccb_done,
  input  logic        sccb_nack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam int unsigned IW      = $clog2(REG_NUM);
  localparam int unsigned CNT_MAX = (POWERUP_CYC > SETTLE_CYC) ? POWERUP_CYC : SETTLE_CYC;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(REG_NUM - 1);
  localparam logic [IW-1:0] X_IDX     = IW'(REG_NUM - 2);
  localparam logic [CW-1:0] PWR_LAST  = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  cfg_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [RW-1:0] retry, retry_n;
  logic          restart_pend, pend_n;
  logic          req_n, busy_n, done_n, err_n, restart;
  logic [7:0]    addr_n, data_n;
  logic [15:0]   rom_word, entry_word;

  camera_reg_rom #(.REG_NUM(REG_NUM)) u_rom (
    .idx  (idx),
    .word (rom_word)
  );

  always_comb begin
    if (idx == LAST_IDX)   entry_word = y_lenth;
    else if (idx == X_IDX) entry_word = x_lenth;
    else                   entry_word = rom_word;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    retry_n = retry;
    pend_n  = restart_pend;
    req_n   = sccb_req;
    addr_n  = sccb_addr;
    data_n  = sccb_data;
    restart = 1'b0;

    case (state)
      WAIT_PWR: begin
        if (!camera_rstn) begin
          restart = 1'b1;
        end else if (cnt == PWR_LAST) begin
          state_n          = REQ;
          cnt_n            = '0;
          req_n            = 1'b1;
          {addr_n, data_n} = entry_word;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      REQ: begin
        // A restart cannot abort the bus write: remember it and let the
        // outstanding transfer finish, then discard its result.
        if (!camera_rstn) pend_n = 1'b1;
        if (sccb_done) begin
          req_n = 1'b0;
          if (restart_pend || !camera_rstn) begin
            restart = 1'b1;
          end else if (!sccb_nack) begin
            retry_n = '0;
            idx_n   = idx + IW'(1);
            if (idx == '0) begin
              state_n = SETTLE;
              cnt_n   = '0;
            end else if (idx == LAST_IDX) begin
              state_n = DONE;
            end else begin
              state_n = GAP;
            end
          end else if (retry < RETRY_MAX) begin
            retry_n = retry + RW'(1);
            state_n = GAP;
          end else begin
            state_n = ERR;
          end
        end
      end
      GAP: begin
        if (!camera_rstn) begin
          restart = 1'b1;
        end else begin
          state_n          = REQ;
          req_n            = 1'b1;
          {addr_n, data_n} = entry_word;
        end
      end
      SETTLE: begin
        if (!camera_rstn) begin
          restart = 1'b1;
        end else if (cnt == SET_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE, ERR: begin
        if (!camera_rstn) restart = 1'b1;
      end
      default: state_n = WAIT_PWR;
    endcase

    if (restart) begin
      state_n = WAIT_PWR;
      cnt_n   = '0;
      idx_n   = '0;
      retry_n = '0;
      pend_n  = 1'b0;
    end

    busy_n = (state_n != DONE) && (state_n != ERR);
    done_n = (state_n == DONE);
    err_n  = (state_n == ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= WAIT_PWR;
      cnt          <= '0;
      idx          <= '0;
      retry        <= '0;
      restart_pend <= 1'b0;
      sccb_req     <= 1'b0;
      sccb_addr    <= '0;
      sccb_data    <= '0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      retry        <= retry_n;
      restart_pend <= pend_n;
      sccb_req     <= req_n;
      sccb_addr    <= addr_n;
      sccb_data    <= data_n;
      cfg_busy     <= busy_n;
      cfg_done     <= done_n;
      cfg_err      <= err_n;
    end
  end

endmodule
